// File: rtl/mathb_fir_sequencer.sv
// mathb_fir_sequencer: start-launched N-tap MAC sequencer (ports: EFPGA2MATHB_CLK/rstn, start/abort/hold/num_taps/bases in, TPRAM read strobes+addresses, MAC clear/clk_en, mac_out in, busy/done/result/result_valid out)
module mathb_fir_sequencer #(
  parameter int ADDR_W = 10,
  parameter int CNT_W = 10,
  parameter int RAM_LAT = 1,
  parameter int MAC_LAT = 2
) (
  input  logic              EFPGA2MATHB_CLK,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  input  logic [CNT_W-1:0]  num_taps,
  input  logic [ADDR_W-1:0] oper_base,
  input  logic [ADDR_W-1:0] coef_base,
  output logic              oper_rd_en,
  output logic              coef_rd_en,
  output logic [ADDR_W-1:0] oper_rd_addr,
  output logic [ADDR_W-1:0] coef_rd_addr,
  output logic              mathb_acc_clear,
  output logic              mathb_clk_en,
  input  logic [31:0]       mac_out,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              result_valid
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, FINISH} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d, idx_q, idx_d;
  logic [ADDR_W-1:0] ob_q, ob_d, cb_q, cb_d;
  logic [RAM_LAT-1:0] pipe_q, pipe_d;
  logic [31:0] result_q, result_d;
  logic rd;
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    idx_d = idx_q;
    ob_d = ob_q;
    cb_d = cb_q;
    result_d = result_q;
    rd = state_q == RUN && !hold;
    pipe_d = RAM_LAT'({pipe_q, rd});
    case (state_q)
      IDLE: if (start) begin
        if (num_taps == '0) begin
          state_d = FINISH;
          result_d = '0;
        end else begin
          state_d = CLEAR;
          n_d = num_taps;
          ob_d = oper_base;
          cb_d = coef_base;
          idx_d = '0;
        end
      end
      CLEAR: state_d = RUN;
      RUN: if (!hold) begin
        idx_d = idx_q == n_q - 1'b1 ? '0 : idx_q + 1'b1;
        state_d = idx_q == n_q - 1'b1 ? DRAIN : RUN;
      end
      DRAIN: if (pipe_q != '0) idx_d = '0;
        else if (idx_q == CNT_W'(MAC_LAT - 1)) begin
          result_d = mac_out;
          state_d = FINISH;
        end else idx_d = idx_q + 1'b1;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      pipe_d = '0;
      result_d = result_q;
    end
  end
  always_ff @(posedge EFPGA2MATHB_CLK) begin
    if (!rstn) begin
      state_q <= IDLE;
      n_q <= '0;
      idx_q <= '0;
      ob_q <= '0;
      cb_q <= '0;
      pipe_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      idx_q <= idx_d;
      ob_q <= ob_d;
      cb_q <= cb_d;
      pipe_q <= pipe_d;
      result_q <= result_d;
    end
  end
  assign oper_rd_en = rd;
  assign coef_rd_en = rd;
  assign oper_rd_addr = rd ? ob_q + ADDR_W'(idx_q) : '0;
  assign coef_rd_addr = rd ? cb_q + ADDR_W'(idx_q) : '0;
  assign mathb_acc_clear = state_q == CLEAR;
  assign mathb_clk_en = mathb_acc_clear | pipe_q[RAM_LAT-1];
  assign busy = state_q != IDLE;
  assign done = state_q == FINISH;
  assign result_valid = done;
  assign result = result_q;
endmodule

// File: tb/tb_mathb_fir_sequencer.sv
// tb_mathb_fir_sequencer: scoreboard bench with TPRAM/MAC plant and dot-product reference model
module tb_mathb_fir_sequencer;
  logic clk = 0, rstn = 0, start = 0, abort = 0, hold = 0;
  logic [9:0] num_taps = 0, oper_base = 0, coef_base = 0;
  logic oper_rd_en, coef_rd_en, mathb_acc_clear, mathb_clk_en, busy, done, result_valid;
  logic [9:0] oper_rd_addr, coef_rd_addr;
  logic [31:0] mac_out = 0, result, acc = 0, last_exp = 0;
  logic [15:0] omem [1024], cmem [1024];
  logic [15:0] od = 0, cd = 0;
  int total = 0, bad = 0, cyc = 0;
  logic [31:0] exp_res [$];
  int exp_cyc [$];
  mathb_fir_sequencer #(.ADDR_W(10), .CNT_W(10), .RAM_LAT(1), .MAC_LAT(2)) dut (
    .EFPGA2MATHB_CLK(clk), .rstn(rstn), .start(start), .abort(abort), .hold(hold),
    .num_taps(num_taps), .oper_base(oper_base), .coef_base(coef_base),
    .oper_rd_en(oper_rd_en), .coef_rd_en(coef_rd_en),
    .oper_rd_addr(oper_rd_addr), .coef_rd_addr(coef_rd_addr),
    .mathb_acc_clear(mathb_acc_clear), .mathb_clk_en(mathb_clk_en), .mac_out(mac_out),
    .busy(busy), .done(done), .result(result), .result_valid(result_valid));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    od <= omem[oper_rd_addr];
    cd <= cmem[coef_rd_addr];
    if (mathb_clk_en) acc <= mathb_acc_clear ? 32'd0 : acc + 32'(od) * 32'(cd);
    mac_out <= acc;
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (done || result_valid) begin
      if (exp_res.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=%0b result_valid=%0b expected no completion (cycle %0d)", done, result_valid, cyc);
      end else begin
        chk("result", result, exp_res.pop_front());
        chk("done_cycle", cyc, exp_cyc.pop_front());
        chk("rv_with_done", {31'd0, result_valid}, {31'd0, done});
      end
    end
  end
  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, {31'd0, oper_rd_en | coef_rd_en}, 0);
    chk({tag, "_rd_addr"}, {12'd0, oper_rd_addr, coef_rd_addr}, 0);
    chk({tag, "_clr_ce"}, {30'd0, mathb_acc_clear, mathb_clk_en}, 0);
    chk({tag, "_busy_done"}, {29'd0, busy, done, result_valid}, 0);
    chk({tag, "_result"}, result, 0);
  endtask
  task automatic run(input int n, input logic [9:0] ob, input logic [9:0] cb, input logic [63:0] hp, input bit noise);
    logic [31:0] sum = 0;
    int holds = 0, reads = 0, j = 1, s, rd = 0, ce = 0;
    bit seen = 0;
    for (int i = 0; i < n; i++) sum += 32'(omem[10'(ob + 10'(i))]) * 32'(cmem[10'(cb + 10'(i))]);
    while (reads < n) begin
      if (j < 64 && hp[j]) holds++;
      else reads++;
      j++;
    end
    @(negedge clk);
    start = 1;
    num_taps = 10'(n);
    oper_base = ob;
    coef_base = cb;
    s = cyc;
    exp_res.push_back(sum);
    exp_cyc.push_back(n == 0 ? s + 1 : s + n + 5 + holds);
    last_exp = sum;
    for (int k = 0; k < n + 80 && !seen; k++) begin
      @(negedge clk);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      hold = k < 64 ? hp[k] : 1'b0;
      #1;
      if (oper_rd_en) begin
        chk("oper_addr", {22'd0, oper_rd_addr}, {22'd0, 10'(ob + 10'(rd))});
        chk("coef_addr", {22'd0, coef_rd_addr}, {22'd0, 10'(cb + 10'(rd))});
        chk("coef_en", {31'd0, coef_rd_en}, 1);
        rd++;
      end
      if (mathb_clk_en) ce++;
      seen = done;
    end
    start = 0;
    hold = 0;
    chk("done_seen", {31'd0, seen}, 1);
    chk("reads", rd, n);
    chk("clk_en_cycles", ce, n == 0 ? 0 : n + 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    bit quiet;
    for (int i = 0; i < 1024; i++) begin
      omem[i] = 16'($urandom);
      cmem[i] = 16'($urandom);
    end
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    rstn = 1;
    run(4, 10'h010, 10'h200, 64'h0, 0);
    run(3, 10'h055, 10'h100, 64'h4, 0);
    run(3, 10'h055, 10'h100, 64'h0, 0);
    run(4, 10'h3FE, 10'h3FF, 64'h0, 0);
    run(0, 10'h123, 10'h321, 64'h0, 0);
    run(5, 10'h080, 10'h090, 64'h0, 0);
    @(negedge clk);
    start = 1;
    num_taps = 5;
    oper_base = 10'h1;
    coef_base = 10'h2;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    abort = 1;
    start = 1;
    @(negedge clk);
    abort = 0;
    start = 0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_ce", {31'd0, mathb_clk_en | mathb_acc_clear}, 0);
    chk("abort_result", result, last_exp);
    quiet = 1;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (oper_rd_en || mathb_clk_en || busy) quiet = 0;
    end
    chk("abort_quiet", {31'd0, quiet}, 1);
    @(negedge clk);
    abort = 1;
    start = 1;
    num_taps = 3;
    @(negedge clk);
    abort = 0;
    start = 0;
    #1;
    chk("idle_abort_busy", {31'd0, busy}, 0);
    quiet = 1;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (oper_rd_en || mathb_clk_en || busy) quiet = 0;
    end
    chk("idle_abort_quiet", {31'd0, quiet}, 1);
    chk("idle_abort_result", result, last_exp);
    @(negedge clk);
    start = 1;
    num_taps = 4;
    oper_base = 10'h20;
    coef_base = 10'h30;
    repeat (6) begin
      @(negedge clk);
      start = 0;
    end
    @(negedge clk);
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    #1;
    chk_zero("midrst");
    run(4, 10'h020, 10'h030, 64'h0, 0);
    for (int t = 0; t < 15; t++)
      run($urandom_range(1, 20), 10'($urandom), 10'($urandom),
          {$urandom, $urandom} & {$urandom, $urandom}, 1);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_res.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
